hamming_byte_encoder: RTL and testbench
=======================================

// Module: hamming_byte_encoder
// PURPOSE
//   Upstream stage of the Hamming(7,4) decoder. Accepts bytes over valid/ready and splits each into
//   two nibbles (low first). Emits each nibble as a 7-bit codeword over valid/ready, in exactly the
//   bit layout the decoder consumes. An optional single-bit fault injector exercises decoder error paths.
// PARAMETERS
//   CNT_W        16   width of saturating emitted-codeword counter
//   INJECT_EN    1    1: fault injector present; 0: inject_* ignored, mask forced to 0
// PORTS
//   clk          in   1      single clock, all state on rising edge
//   rst          in   1      synchronous, active-high reset
//   in_valid     in   1      in_data valid
//   in_data      in   8      byte to encode
//   in_ready     out  1      byte accepted when in_valid & in_ready
//   out_valid    out  1      out_code valid
//   out_code     out  7      Hamming(7,4) codeword
//   out_last     out  1      1 = codeword carries high nibble (second of pair)
//   out_ready    in   1      codeword consumed when out_valid & out_ready
//   inject_req   in   1      1-cycle pulse: corrupt next loaded codeword
//   inject_pos   in   3      bit index 0..6 to flip; 7 = no-op (request dropped)
//   inject_pend  out  1      injection armed, not yet applied
//   cw_count     out  CNT_W  codewords handed off, saturates at all-ones
// BEHAVIOUR
//   Codeword layout for nibble d[3:0]: cw[2]=d0 cw[4]=d1 cw[5]=d2 cw[6]=d3;
//     cw[0]=d0^d1^d3, cw[1]=d0^d2^d3, cw[3]=d1^d2^d3 (zero syndrome at decoder).
//   FSM states IDLE, SEND_LO, SEND_HI; reset -> IDLE.
//   Reset values: out_valid=0, out_code=0, out_last=0, cw_count=0, inject_pend=0,
//     byte holding reg=0. in_ready=0 while rst=1.
//   in_ready = (state==IDLE) | (state==SEND_HI & out_ready). This is a combinational ready path.
//   IDLE: on in handshake, latch byte and load cw(low nibble) into out_code -> SEND_LO;
//     out_valid=1, out_last=0 from next cycle. Latency: byte accepted cycle N, codeword valid N+1.
//   SEND_LO: hold out_code/out_last stable while out_ready=0. On handshake load cw(high nibble),
//     out_last=1 -> SEND_HI.
//   SEND_HI: on handshake with in_valid=1, accept new byte the same cycle and load its low
//     codeword -> SEND_LO (back-to-back, 1 codeword/cycle sustained). On handshake with
//     in_valid=0: out_valid=0 -> IDLE.
//   out_code is registered; it never changes while out_valid & !out_ready.
//   Injection (INJECT_EN=1): inject_req with pos<7 arms pending mask (1<<pos). A new request
//     while pending overwrites the mask. The mask is XORed into the next codeword loaded into
//     out_code. inject_pend clears in that load cycle unless a new inject_req arrives that cycle
//     (new request re-arms). A request in the load cycle itself applies to the following load.
//   cw_count increments by 1 on every out handshake; holds at 2^CNT_W-1.
//   Reset mid-pair: held byte and pending high nibble are discarded; no partial output after.
// TESTING
//   in 0xA5, out_ready=1 -> out_code 0x2D (last=0) then 0x52 (last=1); cw_count=2.
//   in 0x00 then 0xFF back-to-back, out_ready=1 -> 0x00,0x00,0x7F,0x7F on 4 consecutive cycles;
//     in_ready high in each SEND_HI cycle.
//   in 0xA5, out_ready low 5 cycles -> out_code holds 0x2D, in_ready=0, cw_count unchanged.
//   inject_req pos=3 in IDLE, then in 0xA5 -> 0x25 then 0x52; inject_pend 1 until the 0x25 load.
//   CNT_W=2: send 3 bytes -> cw_count saturates at 3. inject_pos=7 -> no corruption, pend=0.
//   rst asserted in SEND_LO -> next cycle out_valid=0, state IDLE, and no high codeword emitted.

Source files
------------

// File: rtl/hamming_byte_encoder.sv
// hamming_byte_encoder
//   Upstream stage of the Hamming(7,4) decoder. It accepts bytes over a
//   valid/ready handshake. Each byte is split into two nibbles, low nibble
//   first, and each nibble goes out as a registered 7-bit codeword over
//   valid/ready. When the codeword layout below is used, a clean codeword
//   gives a zero syndrome at the decoder. An optional fault injector flips
//   one bit of the next loaded codeword so the decoder's error paths can be
//   exercised.
//
// Parameters
//   CNT_W      width of the saturating emitted-codeword counter
//   INJECT_EN  1: fault injector present; 0: inject_* ignored, mask forced 0
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   in_valid     in   in_data valid
//   in_data      in   [7:0] byte to encode
//   in_ready     out  byte accepted when in_valid & in_ready (combinational)
//   out_valid    out  out_code valid
//   out_code     out  [6:0] Hamming(7,4) codeword
//   out_last     out  1 = codeword carries the high nibble
//   out_ready    in   codeword consumed when out_valid & out_ready
//   inject_req   in   pulse: corrupt the next loaded codeword
//   inject_pos   in   [2:0] bit to flip, 7 = request dropped
//   inject_pend  out  injection armed, not yet applied
//   cw_count     out  [CNT_W-1:0] codewords handed off, saturating

module hamming_byte_encoder #(
  parameter int CNT_W     = 16,
  parameter bit INJECT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [6:0]       out_code,
  output logic             out_last,
  input  logic             out_ready,
  input  logic             inject_req,
  input  logic [2:0]       inject_pos,
  output logic             inject_pend,
  output logic [CNT_W-1:0] cw_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  // Layout: cw[2]=d0 cw[4]=d1 cw[5]=d2 cw[6]=d3,
  //         cw[0]=d0^d1^d3 cw[1]=d0^d2^d3 cw[3]=d1^d2^d3.
  function automatic logic [6:0] encode_nibble(input logic [3:0] d);
    logic [6:0] cw;
    cw[0] = d[0] ^ d[1] ^ d[3];
    cw[1] = d[0] ^ d[2] ^ d[3];
    cw[2] = d[0];
    cw[3] = d[1] ^ d[2] ^ d[3];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    return cw;
  endfunction

  state_t             state_q, state_d;
  // Only the high nibble has to survive past the accept cycle: the low
  // nibble is encoded straight from in_data.
  logic [3:0]         hi_q, hi_d;
  logic [6:0]         code_q, code_d;
  logic               last_q, last_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [6:0]         mask_q, mask_d;

  logic               in_hs;
  logic               out_hs;
  logic               load;
  logic [6:0]         apply_mask;

  // Combinational ready: a byte can also be taken in the same cycle that
  // the high codeword is handed off, which gives 1 codeword/cycle.
  assign in_ready = !rst && ((state_q == IDLE) ||
                             ((state_q == SEND_HI) && out_ready));

  assign in_hs      = in_valid && in_ready;
  assign out_hs     = valid_q && out_ready;
  assign apply_mask = (INJECT_EN && pend_q) ? mask_q : 7'd0;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    code_d  = code_q;
    last_d  = last_q;
    valid_d = valid_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_hs) begin
          hi_d    = in_data[7:4];
          code_d  = encode_nibble(in_data[3:0]) ^ apply_mask;
          last_d  = 1'b0;
          valid_d = 1'b1;
          load    = 1'b1;
          state_d = SEND_LO;
        end
      end
      SEND_LO: begin
        if (out_ready) begin
          code_d  = encode_nibble(hi_q) ^ apply_mask;
          last_d  = 1'b1;
          load    = 1'b1;
          state_d = SEND_HI;
        end
      end
      SEND_HI: begin
        if (out_ready) begin
          if (in_valid) begin
            hi_d    = in_data[7:4];
            code_d  = encode_nibble(in_data[3:0]) ^ apply_mask;
            last_d  = 1'b0;
            load    = 1'b1;
            state_d = SEND_LO;
          end else begin
            // out_code keeps its last value; only valid drops.
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_hs && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // A request seen in a load cycle re-arms for the following load; the
  // load itself uses the mask that was already pending.
  always_comb begin
    pend_d = pend_q;
    mask_d = mask_q;
    if (!INJECT_EN) begin
      pend_d = 1'b0;
      mask_d = 7'd0;
    end else if (inject_req && (inject_pos != 3'd7)) begin
      pend_d = 1'b1;
      mask_d = 7'd1 << inject_pos;
    end else if (load) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= 4'd0;
      code_q  <= 7'd0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      pend_q  <= 1'b0;
      mask_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      code_q  <= code_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_code    = code_q;
  assign out_last    = last_q;
  assign inject_pend = pend_q;
  assign cw_count    = cnt_q;

endmodule

// File: tb/tb_hamming_byte_encoder.sv
module tb_hamming_byte_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        out_ready = 1'b0;
  logic        inject_req = 1'b0;
  logic [2:0]  inject_pos = 3'd0;

  logic        in_ready, out_valid, out_last, inject_pend;
  logic [6:0]  out_code;
  logic [15:0] cw_count;

  logic        in_ready2, out_valid2, out_last2, inject_pend2;
  logic [6:0]  out_code2;
  logic [1:0]  cw_count2;

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  hamming_byte_encoder #(.CNT_W(16), .INJECT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_code(out_code),
    .out_last(out_last), .out_ready(out_ready), .inject_req(inject_req),
    .inject_pos(inject_pos), .inject_pend(inject_pend), .cw_count(cw_count)
  );

  hamming_byte_encoder #(.CNT_W(2), .INJECT_EN(1'b1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_code(out_code2),
    .out_last(out_last2), .out_ready(out_ready), .inject_req(inject_req),
    .inject_pos(inject_pos), .inject_pend(inject_pend2), .cw_count(cw_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: pick the three parity bits (positions 1,2,4 in
  // 1-based Hamming numbering) so that the XOR of the positions of all set
  // bits is zero. Data lives at positions 3,5,6,7.
  function automatic logic [6:0] model_enc(input logic [3:0] d);
    int          dpos [4];
    logic [6:0]  cw;
    logic [6:0]  found;
    int          syn;
    dpos = '{3, 5, 6, 7};
    found = 7'd0;
    for (int p = 0; p < 8; p++) begin
      cw = 7'd0;
      for (int i = 0; i < 4; i++) cw[dpos[i]-1] = d[i];
      cw[0] = p[0];
      cw[1] = p[1];
      cw[3] = p[2];
      syn = 0;
      for (int k = 0; k < 7; k++) if (cw[k]) syn = syn ^ (k + 1);
      if (syn == 0) found = cw;
    end
    return found;
  endfunction

  // Stream-level model: what the consumer should currently see.
  logic       m_valid = 1'b0;
  logic       m_last  = 1'b0;
  logic [6:0] m_code  = 7'd0;
  logic [3:0] m_hi    = 4'd0;
  logic       m_pend  = 1'b0;
  logic [6:0] m_mask  = 7'd0;
  int         m_cnt   = 0;

  function automatic logic model_in_ready();
    return !rst && (!m_valid || (m_last && out_ready));
  endfunction

  always @(posedge clk) begin
    logic in_hs, out_hs, load;
    logic [6:0] am;
    if (rst) begin
      m_valid = 1'b0; m_last = 1'b0; m_code = 7'd0; m_hi = 4'd0;
      m_pend = 1'b0; m_mask = 7'd0; m_cnt = 0;
    end else begin
      in_hs  = in_valid && model_in_ready();
      out_hs = m_valid && out_ready;
      am     = m_pend ? m_mask : 7'd0;
      load   = 1'b0;
      if (out_hs) m_cnt++;
      if (out_hs && !m_last) begin
        m_code = model_enc(m_hi) ^ am;
        m_last = 1'b1;
        load   = 1'b1;
      end else if (in_hs) begin
        m_code  = model_enc(in_data[3:0]) ^ am;
        m_hi    = in_data[7:4];
        m_last  = 1'b0;
        m_valid = 1'b1;
        load    = 1'b1;
      end else if (out_hs) begin
        m_valid = 1'b0;
      end
      if (inject_req && inject_pos != 3'd7) begin
        m_pend = 1'b1;
        m_mask = 7'd1 << inject_pos;
      end else if (load) begin
        m_pend = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("out_code",  {25'd0, out_code},  {25'd0, m_code});
      chk("out_last",  {31'd0, out_last},  {31'd0, m_last});
      chk("in_ready",  {31'd0, in_ready},  {31'd0, model_in_ready()});
      chk("inject_pend", {31'd0, inject_pend}, {31'd0, m_pend});
      chk("cw_count",  {16'd0, cw_count},  (m_cnt > 65535) ? 32'd65535 : m_cnt);
      chk("cw_count_sat2", {30'd0, cw_count2}, (m_cnt > 3) ? 32'd3 : m_cnt);
      chk("dut2_out_code", {25'd0, out_code2}, {25'd0, m_code});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; inject_req = 1'b0; inject_pos = 3'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Pin the reference encoder to hand-computed codewords.
    chk("enc_5", {25'd0, model_enc(4'h5)}, 32'h2D);
    chk("enc_A", {25'd0, model_enc(4'hA)}, 32'h52);
    chk("enc_0", {25'd0, model_enc(4'h0)}, 32'h00);
    chk("enc_F", {25'd0, model_enc(4'hF)}, 32'h7F);

    tick();
    tick();
    cmp_en = 1'b1;
    rst = 1'b0;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_code", {25'd0, out_code}, 32'd0);
    chk("rst_count", {16'd0, cw_count}, 32'd0);

    // 0xA5 with out_ready high.
    tick(); in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    #2 chk("a5_in_ready_idle", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    #2 chk("a5_lo", {25'd0, out_code}, 32'h2D);
    chk("a5_lo_last", {31'd0, out_last}, 32'd0);
    tick();
    #2 chk("a5_hi", {25'd0, out_code}, 32'h52);
    chk("a5_hi_last", {31'd0, out_last}, 32'd1);
    tick();
    #2 chk("a5_count", {16'd0, cw_count}, 32'd2);
    chk("a5_done_valid", {31'd0, out_valid}, 32'd0);

    // 0x00 then 0xFF back to back.
    do_reset();
    tick(); in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
    tick(); in_data = 8'hFF;
    #2 chk("b2b_0", {25'd0, out_code}, 32'h00);
    tick();
    #2 chk("b2b_1", {25'd0, out_code}, 32'h00);
    chk("b2b_1_last", {31'd0, out_last}, 32'd1);
    chk("b2b_ready_hi", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    #2 chk("b2b_2", {25'd0, out_code}, 32'h7F);
    tick();
    #2 chk("b2b_3", {25'd0, out_code}, 32'h7F);
    chk("b2b_ready_hi2", {31'd0, in_ready}, 32'd1);
    tick();
    #2 chk("b2b_count", {16'd0, cw_count}, 32'd4);
    chk("b2b_sat2", {30'd0, cw_count2}, 32'd3);

    // Back-pressure hold.
    do_reset();
    tick(); in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      #2 chk("stall_code", {25'd0, out_code}, 32'h2D);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_count", {16'd0, cw_count}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    #2 chk("stall_hi", {25'd0, out_code}, 32'h52);

    // Injection at bit 3.
    do_reset();
    tick(); inject_req = 1'b1; inject_pos = 3'd3;
    tick(); inject_req = 1'b0;
    #2 chk("inj_pend", {31'd0, inject_pend}, 32'd1);
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    #2 chk("inj_lo", {25'd0, out_code}, 32'h25);
    chk("inj_pend_clr", {31'd0, inject_pend}, 32'd0);
    tick();
    #2 chk("inj_hi", {25'd0, out_code}, 32'h52);

    // Injection position 7 is dropped.
    do_reset();
    tick(); inject_req = 1'b1; inject_pos = 3'd7;
    tick(); inject_req = 1'b0;
    #2 chk("inj7_pend", {31'd0, inject_pend}, 32'd0);
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    #2 chk("inj7_lo", {25'd0, out_code}, 32'h2D);

    // Reset in SEND_LO discards the pending high nibble.
    do_reset();
    tick(); in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
    tick(); in_valid = 1'b0; rst = 1'b1;
    #2 chk("rst_mid_ready", {31'd0, in_ready}, 32'd0);
    tick(); rst = 1'b0; out_ready = 1'b1;
    #2 chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      #2 chk("rst_mid_no_hi", {31'd0, out_valid}, 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst        = ($urandom_range(0, 249) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 8'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      inject_req = ($urandom_range(0, 7) == 0);
      inject_pos = 3'($urandom_range(0, 7));
    end
    tick();
    rst = 1'b0; in_valid = 1'b0; inject_req = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
